point_tracker: RTL and testbench
================================

Name: point_tracker

Overview:
- Producer side of the point interface (pointH/pointV/pointVAL) consumed by the trajectory overlay.
- Watches the same rendered pixel stream and classifies each active pixel as marker or not by colour threshold.
- Accumulates the coordinate sums of marker pixels over one frame, then computes the centroid with a sequential divider.
- Emits one point per frame as a single-cycle valid pulse.

Parameters:
FRAME_W, 640, active pixels per line; i_h range 0..FRAME_W-1
FRAME_H, 480, active lines per frame; i_v range 0..FRAME_H-1
R_MIN, 200, marker pixel needs R >= R_MIN
GB_MAX, 80, marker pixel needs G <= GB_MAX and B <= GB_MAX
MIN_PIXELS, 16, minimum marker count for a valid point
SUM_W, 28, coordinate-sum and divider width
CNT_W, 19, marker-count width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_color  in  24  pixel colour {R[23:16],G[15:8],B[7:0]}
i_h  in  10  horizontal position of i_color
i_v  in  10  vertical position of i_color
i_rendering  in  1  pixel is in the active area
o_pointH  out  10  centroid H; held between pulses
o_pointV  out  10  centroid V; held between pulses
o_pointVAL  out  1  one-cycle pulse, new point valid
o_busy  out  1  divider running
o_drop  out  1  one-cycle pulse, frame result discarded

Behaviour:
- Reset, synchronous on i_rst_n=0 at a clock edge:
  - sums, count, state and all outputs go to 0, except o_pointH and o_pointV, which go to 10'h3FF (no point).
  - Reset mid-division aborts the division; no pulse.
- Match: i_rendering=1 and the colour thresholds are met.
- Accumulate, every cycle, independent of the FSM state: on a match, sumH += i_h, sumV += i_v, cnt += 1. Counters saturate at all-ones.
- Frame end: a cycle with i_rendering=1, i_h=FRAME_W-1, i_v=FRAME_H-1 (cycle T). That pixel is included in the sums.
- At the edge ending cycle T:
  - If state is IDLE: snapshot sumH, sumV and cnt (including that pixel) and clear the accumulators for the next frame.
  - If cnt < MIN_PIXELS: pulse o_drop at T+1, stay IDLE, outputs unchanged.
  - Otherwise enter DIV_H.
- FSM: IDLE -> DIV_H -> DIV_V -> OUT -> IDLE.
  - DIV_H: restoring divide, one quotient bit per cycle, SUM_W cycles; snapH / snapCnt (count zero-extended).
  - DIV_V: same, SUM_W cycles, on snapV.
  - OUT: one cycle. o_pointVAL=1; o_pointH and o_pointV updated in the same cycle to the floor quotients, each saturated to 1023.
  - o_busy=1 in DIV_H and DIV_V.
- Latency: with SUM_W=28, o_pointVAL is high in cycle T+57 (DIV_H T+1..T+28, DIV_V T+29..T+56, OUT T+57).
- Frame end while not IDLE:
  - Accumulators still clear; that frame is discarded.
  - o_drop pulses at T+1 and the division in progress continues unaffected.
- i_rendering=0: no accumulation and no frame-end detection, whatever i_h and i_v hold.

Optional Feature:
- Macro: POINT_SMOOTH_EN.
- Defined: in OUT, after the first valid point since reset, output (prev + new) >> 1 per axis, using 11-bit intermediate sums. The first point after reset is output raw.
- Not defined: raw centroid, no history register.

Test Plan:
- Red 4x4 block {255,0,0} at h 100..103, v 50..53, rest black -> o_pointVAL pulses once at T+57 with o_pointH=101, o_pointV=51; o_drop=0.
- Same frame with one pixel of the block black (15 marker pixels) -> no o_pointVAL, o_drop pulse at T+1, outputs stay 3FF/3FF.
- Red pixels driven with i_rendering=0, then a clean frame containing the 4x4 block -> the ignored pixels do not shift the result (101,51).
- i_rst_n=0 for one cycle during DIV_V -> no o_pointVAL, o_busy=0 and outputs 3FF/3FF on the next cycle. The next frame's block yields (101,51).
- Frame-end pixel injected at T+10 -> o_drop pulse at T+11; the pulse at T+57 is still (101,51).
- POINT_SMOOTH_EN: frame 1 block centred (101,51), frame 2 centred (201,151) -> outputs (101,51) then (151,101). Without the macro -> (101,51) then (201,151).

Source files
------------

// File: rtl/point_tracker.sv
// point_tracker: classifies each rendered pixel as marker or background by colour
// threshold, accumulates marker coordinate sums over a frame, and divides them by
// the marker count with a restoring divider (one quotient bit per cycle) to get
// one centroid point per frame.
// Handshake: o_pointVAL is a one-cycle pulse; o_pointH/o_pointV change only in
// that cycle and hold until the next pulse. There is no back-pressure.
// Optional macro POINT_SMOOTH_EN: average each new point with the previous raw point.
module point_tracker #(
    parameter int unsigned FRAME_W    = 640,
    parameter int unsigned FRAME_H    = 480,
    parameter int unsigned R_MIN      = 200,
    parameter int unsigned GB_MAX     = 80,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned SUM_W      = 28,
    parameter int unsigned CNT_W      = 19
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [23:0] i_color,
    input  logic [9:0]  i_h,
    input  logic [9:0]  i_v,
    input  logic        i_rendering,
    output logic [9:0]  o_pointH,
    output logic [9:0]  o_pointV,
    output logic        o_pointVAL,
    output logic        o_busy,
    output logic        o_drop
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV_H = 2'd1,
        S_DIV_V = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int unsigned      STEP_W    = $clog2(SUM_W);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

    // Quotients above 1023 cannot be represented on the point interface.
    function automatic logic [9:0] sat10(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:10]) ? 10'h3FF : q[9:0];
    endfunction

    // State is kept in plain named flops so checkers can bind to state_q directly.
    state_t              state_q, state_d;
    logic [SUM_W-1:0]    sum_h_q, sum_h_d;
    logic [SUM_W-1:0]    sum_v_q, sum_v_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]    rem_q, rem_d;
    logic [SUM_W-1:0]    quo_q, quo_d;
    logic [SUM_W-1:0]    div_q, div_d;
    logic [SUM_W-1:0]    snap_v_q, snap_v_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [9:0]          quot_h_q, quot_h_d;
    logic [9:0]          point_h_q, point_h_d;
    logic [9:0]          point_v_q, point_v_d;
    logic                drop_q, drop_d;
`ifdef POINT_SMOOTH_EN
    logic [9:0]          prev_h_q, prev_h_d;
    logic [9:0]          prev_v_q, prev_v_d;
    logic                have_prev_q, have_prev_d;
    logic [10:0]         avg_h, avg_v;
`endif

    logic                pix_match;
    logic                frame_end;
    logic [SUM_W:0]      add_h, add_v;
    logic [SUM_W-1:0]    acc_h, acc_v;
    logic [CNT_W-1:0]    acc_cnt;
    logic [SUM_W:0]      rem_shift;
    logic [SUM_W-1:0]    quo_shift;
    logic [SUM_W-1:0]    rem_next, quo_next;
    logic [9:0]          raw_h, raw_v;

    // Pixel classification and saturating accumulation; accumulators clear at every frame end.
    always_comb begin
        pix_match = i_rendering &&
                    (i_color[23:16] >= 8'(R_MIN)) &&
                    (i_color[15:8]  <= 8'(GB_MAX)) &&
                    (i_color[7:0]   <= 8'(GB_MAX));
        frame_end = i_rendering &&
                    (i_h == 10'(FRAME_W - 1)) &&
                    (i_v == 10'(FRAME_H - 1));
        add_h   = {1'b0, sum_h_q} + (SUM_W+1)'(i_h);
        add_v   = {1'b0, sum_v_q} + (SUM_W+1)'(i_v);
        acc_h   = sum_h_q;
        acc_v   = sum_v_q;
        acc_cnt = cnt_q;
        if (pix_match) begin
            acc_h   = add_h[SUM_W] ? '1 : add_h[SUM_W-1:0];
            acc_v   = add_v[SUM_W] ? '1 : add_v[SUM_W-1:0];
            acc_cnt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        sum_h_d = frame_end ? '0 : acc_h;
        sum_v_d = frame_end ? '0 : acc_v;
        cnt_d   = frame_end ? '0 : acc_cnt;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, quo_q[SUM_W-1]};
        quo_shift = {quo_q[SUM_W-2:0], 1'b0};
        if (rem_shift >= {1'b0, div_q}) begin
            rem_next = SUM_W'(rem_shift - {1'b0, div_q});
            quo_next = quo_shift | SUM_W'(1);
        end else begin
            rem_next = rem_shift[SUM_W-1:0];
            quo_next = quo_shift;
        end
    end

    // FSM next state, divider sequencing, snapshot and output point update.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        snap_v_d  = snap_v_q;
        step_d    = step_q;
        quot_h_d  = quot_h_q;
        point_h_d = point_h_q;
        point_v_d = point_v_q;
        drop_d    = 1'b0;
        raw_h     = quot_h_q;
        raw_v     = sat10(quo_next);
`ifdef POINT_SMOOTH_EN
        prev_h_d    = prev_h_q;
        prev_v_d    = prev_v_q;
        have_prev_d = have_prev_q;
        avg_h       = {1'b0, prev_h_q} + {1'b0, raw_h};
        avg_v       = {1'b0, prev_v_q} + {1'b0, raw_v};
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_end) begin
                    quo_d    = acc_h;
                    snap_v_d = acc_v;
                    div_d    = SUM_W'(acc_cnt);
                    rem_d    = '0;
                    step_d   = '0;
                    if (acc_cnt < CNT_W'(MIN_PIXELS)) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = S_DIV_H;
                    end
                end
            end
            S_DIV_H: begin
                rem_d  = rem_next;
                quo_d  = quo_next;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    quot_h_d = sat10(quo_next);
                    quo_d    = snap_v_q;
                    rem_d    = '0;
                    step_d   = '0;
                    state_d  = S_DIV_V;
                end
            end
            S_DIV_V: begin
                rem_d  = rem_next;
                quo_d  = quo_next;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = S_OUT;
`ifdef POINT_SMOOTH_EN
                    if (have_prev_q) begin
                        point_h_d = 10'(avg_h >> 1);
                        point_v_d = 10'(avg_v >> 1);
                    end else begin
                        point_h_d = raw_h;
                        point_v_d = raw_v;
                    end
                    prev_h_d    = raw_h;
                    prev_v_d    = raw_v;
                    have_prev_d = 1'b1;
`else
                    point_h_d = raw_h;
                    point_v_d = raw_v;
`endif
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A frame ending while the divider is occupied is discarded; the division carries on.
        if (frame_end && (state_q != S_IDLE)) begin
            drop_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            sum_h_q   <= '0;
            sum_v_q   <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            snap_v_q  <= '0;
            step_q    <= '0;
            quot_h_q  <= '0;
            point_h_q <= 10'h3FF;
            point_v_q <= 10'h3FF;
            drop_q    <= 1'b0;
`ifdef POINT_SMOOTH_EN
            prev_h_q    <= '0;
            prev_v_q    <= '0;
            have_prev_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sum_h_q   <= sum_h_d;
            sum_v_q   <= sum_v_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            snap_v_q  <= snap_v_d;
            step_q    <= step_d;
            quot_h_q  <= quot_h_d;
            point_h_q <= point_h_d;
            point_v_q <= point_v_d;
            drop_q    <= drop_d;
`ifdef POINT_SMOOTH_EN
            prev_h_q    <= prev_h_d;
            prev_v_q    <= prev_v_d;
            have_prev_q <= have_prev_d;
`endif
        end
    end

    assign o_pointH   = point_h_q;
    assign o_pointV   = point_v_q;
    assign o_pointVAL = (state_q == S_OUT);
    assign o_busy     = (state_q == S_DIV_H) || (state_q == S_DIV_V);
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_point_tracker.sv
// tb_point_tracker: directed and random pixel streams for point_tracker, checked
// every cycle against a frame-level reference model (sums, count, division with
// plain integer arithmetic, and an expected-point queue with scheduled cycles).
module tb_point_tracker;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [23:0] i_color = '0;
    logic [9:0]  i_h = '0;
    logic [9:0]  i_v = '0;
    logic        i_rendering = 1'b0;
    logic [9:0]  o_pointH;
    logic [9:0]  o_pointV;
    logic        o_pointVAL;
    logic        o_busy;
    logic        o_drop;

    // Clock.
    always #5 i_clk = ~i_clk;

    point_tracker dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_color     (i_color),
        .i_h         (i_h),
        .i_v         (i_v),
        .i_rendering (i_rendering),
        .o_pointH    (o_pointH),
        .o_pointV    (o_pointV),
        .o_pointVAL  (o_pointVAL),
        .o_busy      (o_busy),
        .o_drop      (o_drop)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int          cyc       = 0;
    int          out_cyc   = -1;
    bit          chk_en    = 1'b0;
    bit          drop_pend = 1'b0;
    int          m_sum_h   = 0;
    int          m_sum_v   = 0;
    int          m_cnt     = 0;
    int          exp_h     = 1023;
    int          exp_v     = 1023;
    int          prev_h    = 0;
    int          prev_v    = 0;
    bit          have_prev = 1'b0;
    logic [19:0] exp_q[$];

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        out_cyc   = -1;
        drop_pend = 1'b0;
        m_sum_h   = 0;
        m_sum_v   = 0;
        m_cnt     = 0;
        exp_h     = 1023;
        exp_v     = 1023;
        have_prev = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle, check that cycle's outputs, then advance the model.
    task automatic tick(input logic [23:0] col, input logic [9:0] h, input logic [9:0] v,
                        input logic rend, input logic rst_n);
        logic [19:0] raw;
        int          rh, rv, qh, qv;
        bit          mt, fe;
        i_color     = col;
        i_h         = h;
        i_v         = v;
        i_rendering = rend;
        i_rst_n     = rst_n;
        if (cyc == out_cyc) begin
            raw = exp_q.pop_front();
            rh  = int'(raw[19:10]);
            rv  = int'(raw[9:0]);
`ifdef POINT_SMOOTH_EN
            if (have_prev) begin
                exp_h = (prev_h + rh) / 2;
                exp_v = (prev_v + rv) / 2;
            end else begin
                exp_h = rh;
                exp_v = rv;
            end
            prev_h    = rh;
            prev_v    = rv;
            have_prev = 1'b1;
`else
            exp_h = rh;
            exp_v = rv;
`endif
        end
        if (chk_en) begin
            chk("val",  10'(o_pointVAL), 10'(cyc == out_cyc));
            chk("drop", 10'(o_drop), 10'(drop_pend));
            chk("busy", 10'(o_busy), 10'(out_cyc >= 0 && cyc >= out_cyc - 56 && cyc < out_cyc));
            chk("ph",   o_pointH, 10'(exp_h));
            chk("pv",   o_pointV, 10'(exp_v));
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            mt = rend && col[23:16] >= 8'd200 && col[15:8] <= 8'd80 && col[7:0] <= 8'd80;
            fe = rend && h == 10'd639 && v == 10'd479;
            if (mt) begin
                m_sum_h += int'(h);
                m_sum_v += int'(v);
                m_cnt   += 1;
            end
            drop_pend = 1'b0;
            if (fe) begin
                if (cyc > out_cyc && m_cnt >= 16) begin
                    qh = m_sum_h / m_cnt;
                    qv = m_sum_v / m_cnt;
                    if (qh > 1023) qh = 1023;
                    if (qv > 1023) qv = 1023;
                    out_cyc = cyc + 57;
                    exp_q.push_back({10'(qh), 10'(qv)});
                end else begin
                    drop_pend = 1'b1;
                end
                m_sum_h = 0;
                m_sum_v = 0;
                m_cnt   = 0;
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    function automatic logic [23:0] rand_marker();
        return {8'($urandom_range(200, 255)), 8'($urandom_range(0, 80)), 8'($urandom_range(0, 80))};
    endfunction

    function automatic logic [23:0] rand_other();
        case ($urandom_range(0, 2))
            0:       return {8'($urandom_range(0, 199)), 8'($urandom_range(0, 80)), 8'($urandom_range(0, 80))};
            1:       return {8'($urandom_range(200, 255)), 8'($urandom_range(81, 255)), 8'($urandom_range(0, 80))};
            default: return {8'($urandom_range(200, 255)), 8'($urandom_range(0, 80)), 8'($urandom_range(81, 255))};
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                tick(rand_marker(), 10'd639, 10'd479, 1'b0, 1'b1);
            else
                tick(24'($urandom), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 1'b0, 1'b1);
        end
    endtask

    task automatic frame_end_px(input logic [23:0] col);
        tick(col, 10'd639, 10'd479, 1'b1, 1'b1);
    endtask

    // 4x4 marker block at (h0,v0) with background pixels between rows; skip drops one pixel.
    task automatic send_block(input int h0, input int v0, input bit skip);
        for (int dv = 0; dv < 4; dv++) begin
            for (int dh = 0; dh < 4; dh++) begin
                if (skip && dh == 0 && dv == 0)
                    tick(24'h000000, 10'(h0 + dh), 10'(v0 + dv), 1'b1, 1'b1);
                else
                    tick(24'hFF0000, 10'(h0 + dh), 10'(v0 + dv), 1'b1, 1'b1);
            end
            tick(24'h000000, 10'($urandom_range(0, 638)), 10'($urandom_range(0, 478)), 1'b1, 1'b1);
        end
        frame_end_px(24'h000000);
    endtask

    task automatic random_frame();
        int len;
        len = $urandom_range(8, 40);
        for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 3))
                0, 1: tick(rand_marker(), 10'($urandom_range(0, 639)), 10'($urandom_range(0, 478)), 1'b1, 1'b1);
                2:    tick(rand_other(), 10'($urandom_range(0, 639)), 10'($urandom_range(0, 478)), 1'b1, 1'b1);
                default: tick(rand_marker(), 10'd639, 10'd479, 1'b0, 1'b1);
            endcase
        end
        if ($urandom_range(0, 1) == 0)
            tick({8'd200, 8'd80, 8'd80}, 10'd639, 10'd479, 1'b1, 1'b1);
        else
            tick({8'd199, 8'd80, 8'd80}, 10'd639, 10'd479, 1'b1, 1'b1);
    endtask

    // Directed steps followed by a random phase.
    initial begin
        tick(24'h0, 10'd0, 10'd0, 1'b0, 1'b0);
        chk_en = 1'b1;

        // 15 marker pixels: dropped, outputs keep the reset value.
        send_block(100, 50, 1'b1);
        idle(60);
        chk("short_h", o_pointH, 10'h3FF);
        chk("short_v", o_pointV, 10'h3FF);

        // Non-rendering red pixels are ignored, then the clean block gives (101,51).
        for (int i = 0; i < 6; i++)
            tick(24'hFF0000, 10'($urandom_range(600, 639)), 10'($urandom_range(400, 479)), 1'b0, 1'b1);
        frame_end_px(24'hFF0000);
        send_block(100, 50, 1'b0);
        idle(60);
        chk("blk_h", o_pointH, 10'd101);
        chk("blk_v", o_pointV, 10'd51);

        // Second point: raw (201,151) or averaged (151,101).
        send_block(200, 150, 1'b0);
        idle(60);
`ifdef POINT_SMOOTH_EN
        chk("smooth_h", o_pointH, 10'd151);
        chk("smooth_v", o_pointV, 10'd101);
`else
        chk("raw2_h", o_pointH, 10'd201);
        chk("raw2_v", o_pointV, 10'd151);
`endif

        // Reset during the vertical division aborts the point.
        send_block(100, 50, 1'b0);
        idle(40);
        tick(24'h0, 10'd0, 10'd0, 1'b0, 1'b0);
        idle(60);
        chk("abort_h", o_pointH, 10'h3FF);
        send_block(100, 50, 1'b0);
        idle(60);
        chk("after_rst_h", o_pointH, 10'd101);
        chk("after_rst_v", o_pointV, 10'd51);

        // Frame end injected at T+10 while dividing: drop, point still delivered.
        send_block(100, 50, 1'b0);
        idle(9);
        frame_end_px(24'hFF0000);
        idle(60);
        chk("inj_h", o_pointH, 10'd101);
        chk("inj_v", o_pointV, 10'd51);

        // Random frames with random gaps, occasional resets.
        for (int f = 0; f < 30; f++) begin
            random_frame();
            idle($urandom_range(0, 70));
            if ($urandom_range(0, 9) == 0)
                tick(24'h0, 10'd0, 10'd0, 1'b0, 1'b0);
        end
        idle(70);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
